// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: default word width and the
// transmitter state encoding.
package serial_pkg;

    localparam int SER_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: takes a word over valid/ready and
// shifts it out LSB first, one bit per tick, each bit marked by ser_strobe.
module piso_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             tick,
    output logic             ser_bit,
    output logic             ser_strobe,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic             last_tick;

    assign last_tick = tick && (cnt == LAST);
    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (in_valid) next_state = ST_SEND;
            ST_SEND: if (last_tick) next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Strobe and done are single-cycle pulses; ser_bit holds between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            cnt        <= '0;
            ser_bit    <= 1'b0;
            ser_strobe <= 1'b0;
            done       <= 1'b0;
        end else begin
            ser_strobe <= 1'b0;
            done       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        shreg <= din;
                        cnt   <= '0;
                    end
                end
                ST_SEND: begin
                    if (tick) begin
                        ser_bit    <= shreg[0];
                        ser_strobe <= 1'b1;
                        shreg      <= shreg >> 1;
                        // The counter parks at LAST so it never wraps.
                        if (cnt == LAST) begin
                            done <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer with a loopback shift-register
// receiver model and a bit-level reference derived from the input words.
module tb_piso_serializer;
    import serial_pkg::*;

    localparam int W = SER_WIDTH;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] din = '0;
    logic         tick = 1'b0;
    logic         ser_bit;
    logic         ser_strobe;
    logic         busy;
    logic         done;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    piso_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .din        (din),
        .tick       (tick),
        .ser_bit    (ser_bit),
        .ser_strobe (ser_strobe),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model: shift-enable from ser_strobe, serial input from ser_bit.
    logic [W-1:0] rx_q;
    always @(posedge clk) begin
        if (ser_strobe) rx_q <= {ser_bit, rx_q[W-1:1]};
    end

    logic got_bits[$];
    int   got_cyc[$];
    int   accept_cyc;
    int   done_cyc;
    int   done_cnt;
    int   ready_cyc;
    bit   timeout;
    bit   busy_gap;

    function automatic logic [W-1:0] got_word();
        logic [W-1:0] w = '0;
        for (int i = 0; i < got_bits.size() && i < W; i++) w[i] = got_bits[i];
        return w;
    endfunction

    function automatic int bad_gaps(input int period);
        int n = 0;
        for (int i = 1; i < got_cyc.size(); i++)
            if (got_cyc[i] - got_cyc[i-1] != period) n++;
        return n;
    endfunction

    // Offers one word, then ticks every 'period' cycles while recording every
    // strobe until in_ready comes back. reset_at >= 0 pulses rst once that
    // many strobes have been seen.
    task automatic run_word(input logic [W-1:0] word, input int period,
                            input int reset_at, input bit intrude);
        int  budget = 0;
        bit  did_reset = 0;
        got_bits.delete();
        got_cyc.delete();
        done_cnt  = 0;
        done_cyc  = -1;
        ready_cyc = -1;
        timeout   = 0;
        busy_gap  = 0;
        in_valid  = 0;
        tick      = 0;
        while (!in_ready && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!in_ready) timeout = 1;
        in_valid = 1;
        din      = word;
        tick     = (period == 1);
        @(posedge clk); #1;
        accept_cyc = cyc;
        in_valid   = intrude;
        din        = intrude ? W'(16'hDEAD) : W'($urandom);
        for (int k = 0; k < W * period + 50; k++) begin
            tick = ((k % period) == 0);
            if (!did_reset && reset_at >= 0 && got_bits.size() == reset_at) begin
                rst       = 1;
                did_reset = 1;
            end
            @(posedge clk); #1;
            rst = 0;
            if (ser_strobe) begin
                got_bits.push_back(ser_bit);
                got_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (in_ready) begin
                ready_cyc = cyc;
                break;
            end
            if (!busy) busy_gap = 1;
        end
        if (ready_cyc < 0) timeout = 1;
        in_valid = 0;
        tick     = 0;
    endtask

    task automatic test_reset();
        rst      = 1;
        in_valid = 1;
        din      = W'($urandom);
        tick     = 1;
        repeat (3) begin @(posedge clk); #1; end
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (ser_strobe !== 1'b0) $display("FAIL reset_strobe got %b want 0", ser_strobe); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
        total_cnt++; if (ser_bit !== 1'b0) $display("FAIL reset_ser_bit got %b want 0", ser_bit); else pass_cnt++;
        rst      = 0;
        in_valid = 0;
        tick     = 0;
        @(posedge clk); #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_no_accept busy got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_single();
        logic exp_bits [W] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
        int   bad = 0;
        run_word(W'(16'hA5C3), 1, -1, 0);
        for (int i = 0; i < W; i++)
            if (i >= got_bits.size() || got_bits[i] !== exp_bits[i]) bad++;
        total_cnt++; if (timeout) $display("FAIL single_timeout got 1 want 0"); else pass_cnt++;
        total_cnt++; if (got_bits.size() != W) $display("FAIL single_count got %0d want %0d", got_bits.size(), W); else pass_cnt++;
        total_cnt++; if (bad != 0) $display("FAIL single_bits got %0d wrong bits (word %h) want 0", bad, got_word()); else pass_cnt++;
        total_cnt++; if (got_cyc.size() == 0 || got_cyc[0] != accept_cyc + 1) $display("FAIL single_first_latency got cycle %0d want %0d", got_cyc.size() ? got_cyc[0] : -1, accept_cyc + 1); else pass_cnt++;
        total_cnt++; if (bad_gaps(1) != 0) $display("FAIL single_consecutive got %0d gaps want 0", bad_gaps(1)); else pass_cnt++;
        total_cnt++; if (done_cnt != 1) $display("FAIL single_done_count got %0d want 1", done_cnt); else pass_cnt++;
        total_cnt++; if (got_cyc.size() == 0 || done_cyc != got_cyc[got_cyc.size()-1]) $display("FAIL single_done_align got %0d want last strobe cycle", done_cyc); else pass_cnt++;
        total_cnt++; if (ready_cyc != done_cyc + 1) $display("FAIL single_ready_return got %0d want %0d", ready_cyc, done_cyc + 1); else pass_cnt++;
        total_cnt++; if (busy_gap) $display("FAIL single_busy got gap want steady high"); else pass_cnt++;
        total_cnt++; if (ser_strobe !== 1'b0) $display("FAIL single_idle_strobe got %b want 0", ser_strobe); else pass_cnt++;
    endtask

    task automatic test_loopback();
        int prev_ready;
        run_word(W'(16'h8001), 1, -1, 0);
        total_cnt++; if (rx_q !== W'(16'h8001)) $display("FAIL loop_first got %h want 8001", rx_q); else pass_cnt++;
        prev_ready = ready_cyc;
        run_word(W'(16'hFFFF), 1, -1, 0);
        total_cnt++; if (rx_q !== W'(16'hFFFF)) $display("FAIL loop_second got %h want ffff", rx_q); else pass_cnt++;
        total_cnt++; if (accept_cyc != prev_ready + 1) $display("FAIL back_to_back_gap got %0d want %0d", accept_cyc, prev_ready + 1); else pass_cnt++;
    endtask

    task automatic test_slow();
        run_word(W'(16'h1234), 4, -1, 0);
        total_cnt++; if (got_bits.size() != W) $display("FAIL slow_count got %0d want %0d", got_bits.size(), W); else pass_cnt++;
        total_cnt++; if (got_word() !== W'(16'h1234)) $display("FAIL slow_data got %h want 1234", got_word()); else pass_cnt++;
        total_cnt++; if (bad_gaps(4) != 0) $display("FAIL slow_spacing got %0d bad gaps want 0", bad_gaps(4)); else pass_cnt++;
        total_cnt++; if (busy_gap) $display("FAIL slow_busy got gap want steady high"); else pass_cnt++;
        total_cnt++; if (done_cnt != 1) $display("FAIL slow_done got %0d want 1", done_cnt); else pass_cnt++;
    endtask

    task automatic test_busy_reject();
        run_word(W'(16'h00FF), 1, -1, 1);
        total_cnt++; if (got_bits.size() != W) $display("FAIL busy_count got %0d want %0d", got_bits.size(), W); else pass_cnt++;
        total_cnt++; if (got_word() !== W'(16'h00FF)) $display("FAIL busy_data got %h want 00ff", got_word()); else pass_cnt++;
        total_cnt++; if (done_cnt != 1 || ready_cyc != done_cyc + 1) $display("FAIL busy_done got done %0d ready %0d want 1 and %0d", done_cnt, ready_cyc, done_cyc + 1); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int extra = 0;
        run_word(W'(16'hFFFF), 1, 7, 0);
        total_cnt++; if (got_bits.size() != 7) $display("FAIL mid_strobes got %0d want 7", got_bits.size()); else pass_cnt++;
        total_cnt++; if (done_cnt != 0) $display("FAIL mid_done got %0d want 0", done_cnt); else pass_cnt++;
        tick = 1;
        repeat (20) begin
            @(posedge clk); #1;
            if (ser_strobe || done || busy) extra++;
        end
        tick = 0;
        total_cnt++; if (extra != 0) $display("FAIL mid_quiet got %0d active cycles want 0", extra); else pass_cnt++;
        run_word(W'(16'h0001), 1, -1, 0);
        total_cnt++; if (got_bits.size() != W || got_word() !== W'(16'h0001)) $display("FAIL mid_next got %h (%0d bits) want 0001", got_word(), got_bits.size()); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [W-1:0] word;
        int           period;
        for (int n = 0; n < 8; n++) begin
            word   = W'($urandom);
            period = $urandom_range(1, 4);
            run_word(word, period, -1, 0);
            total_cnt++; if (got_bits.size() != W || got_word() !== word) $display("FAIL rand_data[%0d] got %h (%0d bits) want %h", n, got_word(), got_bits.size(), word); else pass_cnt++;
            total_cnt++; if (bad_gaps(period) != 0 || done_cnt != 1) $display("FAIL rand_timing[%0d] got %0d gaps %0d done want 0 and 1", n, bad_gaps(period), done_cnt); else pass_cnt++;
            total_cnt++; if (rx_q !== word) $display("FAIL rand_loop[%0d] got %h want %h", n, rx_q, word); else pass_cnt++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_loopback();
        test_slow();
        test_busy_reject();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
